// File: rtl/matrix_mult_stream.sv
// Streaming NxN matrix multiplier C = A x B: loads A then B as row-major beats,
// accumulates C over N cycles on an NxN MAC array, then drains C with backpressure.
module matrix_mult_stream #(
  parameter int DATA_W = 8,
  parameter int N      = 4,
  parameter int LANES  = 4,
  parameter int SIGNED = 0,
  parameter int ACC_W  = 2*DATA_W + $clog2(N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*ACC_W-1:0]   out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam int BEATS = N*N/LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int KW    = (N > 1) ? $clog2(N) : 1;
  localparam int EW    = (N*N > 1) ? $clog2(N*N) : 1;
  localparam int PW    = 2*DATA_W;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] a_mem [N*N];
  logic [DATA_W-1:0] b_mem [N*N];
  logic [ACC_W-1:0]  c_mem [N*N];
  logic [ACC_W-1:0]  term  [N*N];

  logic [BW-1:0] in_beat;
  logic [BW-1:0] out_beat;
  logic [KW-1:0] k_cnt;
  logic [LANES*ACC_W-1:0] drain_beat;

  logic in_fire, in_last_beat, k_last, drain_load, drain_done;

  assign in_ready     = (state == LOAD_A) || (state == LOAD_B);
  assign busy         = (state == COMPUTE) || (state == DRAIN);
  assign in_fire      = in_valid && in_ready;
  assign in_last_beat = (in_beat == BW'(BEATS-1));
  assign k_last       = (k_cnt == KW'(N-1));
  // Output register refills on entry to DRAIN and on every non-final handshake,
  // so beats stream back-to-back while out_data stays stable under stall.
  assign drain_load   = (state == DRAIN) && (!out_valid || (out_ready && !out_last));
  assign drain_done   = out_valid && out_ready && out_last;

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD_A;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_A:  if (in_fire && in_last_beat) state_nxt = LOAD_B;
      LOAD_B:  if (in_fire && in_last_beat) state_nxt = COMPUTE;
      COMPUTE: if (k_last)                  state_nxt = DRAIN;
      DRAIN:   if (drain_done)              state_nxt = LOAD_A;
      default:                              state_nxt = LOAD_A;
    endcase
  end

  always_comb begin
    logic [DATA_W-1:0]     a_op;
    logic [DATA_W-1:0]     b_op;
    logic signed [PW-1:0]  prod_s;
    logic [PW-1:0]         prod_u;
    a_op   = '0;
    b_op   = '0;
    prod_s = '0;
    prod_u = '0;
    for (int e = 0; e < N*N; e++) term[e] = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_op = a_mem[EW'(i*N + int'(k_cnt))];
        b_op = b_mem[EW'(int'(k_cnt)*N + j)];
        if (SIGNED != 0) begin
          prod_s = PW'($signed(a_op)) * PW'($signed(b_op));
          term[EW'(i*N + j)] = ACC_W'(prod_s);
        end else begin
          prod_u = PW'(a_op) * PW'(b_op);
          term[EW'(i*N + j)] = ACC_W'(prod_u);
        end
      end
    end
  end

  always_comb begin
    drain_beat = '0;
    for (int l = 0; l < LANES; l++)
      drain_beat[l*ACC_W +: ACC_W] = c_mem[EW'(int'(out_beat)*LANES + l)];
  end

  // Matrix storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && in_fire) begin
      for (int l = 0; l < LANES; l++) begin
        if (state == LOAD_A) a_mem[EW'(int'(in_beat)*LANES + l)] <= in_data[l*DATA_W +: DATA_W];
        else                 b_mem[EW'(int'(in_beat)*LANES + l)] <= in_data[l*DATA_W +: DATA_W];
      end
    end
    if (!reset && state == COMPUTE) begin
      for (int e = 0; e < N*N; e++)
        c_mem[EW'(e)] <= ((k_cnt == '0) ? '0 : c_mem[EW'(e)]) + term[EW'(e)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_beat   <= '0;
      out_beat  <= '0;
      k_cnt     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (in_fire) in_beat <= in_last_beat ? '0 : in_beat + BW'(1);
      if (state == COMPUTE) k_cnt <= k_last ? '0 : k_cnt + KW'(1);
      if (drain_load) begin
        out_data  <= drain_beat;
        out_valid <= 1'b1;
        out_last  <= (out_beat == BW'(BEATS-1));
        out_beat  <= (out_beat == BW'(BEATS-1)) ? '0 : out_beat + BW'(1);
      end else if (drain_done) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_mult_stream.sv
// Scoreboard bench: three instances (unsigned 4x4, signed 4x4, unsigned 8x8 with 2 lanes)
// fed directed matrices; monitors pop expected beats whenever a DUT hands over a beat.
module tb_matrix_mult_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  or_mode;
  logic        tog = 1'b0;
  logic        out_ready;
  int          sel;

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;
  assign out_ready = (or_mode == 2'd0) ? 1'b1 : (or_mode == 2'd1) ? tog : 1'b0;

  logic        rdy0, ov0, ol0, busy0;
  logic [71:0] od0;
  logic        rdy1, ov1, ol1, busy1;
  logic [71:0] od1;
  logic        rdy2, ov2, ol2, busy2;
  logic [21:0] od2;

  matrix_mult_stream dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 0), .in_ready(rdy0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_last(ol0), .busy(busy0));

  matrix_mult_stream #(.SIGNED(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 1), .in_ready(rdy1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_last(ol1), .busy(busy1));

  matrix_mult_stream #(.DATA_W(4), .N(8), .LANES(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 2), .in_ready(rdy2),
    .in_data(in_data[7:0]), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .out_last(ol2), .busy(busy2));

  logic [72:0] q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;
  int hs0 = 0;
  int ma[64], mb[64], mc[64];

  task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int dut);
    return (dut == 0) ? q0.size() : (dut == 1) ? q1.size() : q2.size();
  endfunction

  function automatic logic cur_rdy(input int dut);
    return (dut == 0) ? rdy0 : (dut == 1) ? rdy1 : rdy2;
  endfunction

  task automatic mon_beat(input int dut, input logic [72:0] act);
    if (qsize(dut) == 0) begin
      checks++;
      errors++;
      $display("FAIL extra_beat_dut%0d actual=%h required=none", dut, act);
    end else if (dut == 0) chk("dut0_beat", act, q0.pop_front());
    else if (dut == 1)     chk("dut1_beat", act, q1.pop_front());
    else                   chk("dut2_beat", act, q2.pop_front());
  endtask

  logic [72:0] held;
  bit          held_v = 0;

  always @(negedge clk) begin
    if (reset) held_v = 0;
    else if (ov0) begin
      if (held_v) chk("hold_stable", {ol0, od0}, held);
      if (out_ready) begin
        mon_beat(0, {ol0, od0});
        hs0++;
        held_v = 0;
      end else begin
        held   = {ol0, od0};
        held_v = 1;
      end
    end
  end

  always @(negedge clk) if (!reset && ov1 && out_ready) mon_beat(1, {ol1, od1});
  always @(negedge clk) if (!reset && ov2 && out_ready) mon_beat(2, {ol2, 50'b0, od2});

  task automatic model(input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        int s = 0;
        for (int k = 0; k < n; k++) s += ma[i*n+k] * mb[k*n+j];
        mc[i*n+j] = s;
      end
  endtask

  task automatic push_exp(input int dut, input int n, input int lanes, input int accw, input int nbeats);
    int beats = n*n/lanes;
    for (int b = 0; b < nbeats; b++) begin
      logic [72:0] v = '0;
      for (int l = 0; l < lanes; l++) begin
        logic [63:0] val = 64'(mc[b*lanes+l]) & ((64'd1 << accw) - 64'd1);
        v = v | (73'(val) << (l*accw));
      end
      v[72] = (b == beats-1);
      if (dut == 0) q0.push_back(v);
      else if (dut == 1) q1.push_back(v);
      else q2.push_back(v);
    end
  endtask

  task automatic send(input int dut, input int n, input int lanes, input int dw, input bit gaps);
    int beats = n*n/lanes;
    int mask  = (1 << dw) - 1;
    sel = dut;
    for (int m = 0; m < 2; m++)
      for (int b = 0; b < beats; b++) begin
        bit ok = 0;
        if (gaps) begin
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        in_data = '0;
        for (int l = 0; l < lanes; l++) begin
          int e = b*lanes + l;
          int v = (m == 0) ? ma[e] : mb[e];
          in_data = in_data | (32'(v & mask) << (l*dw));
        end
        in_valid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
          @(negedge clk);
          ok = cur_rdy(dut);
          @(posedge clk);
          #1;
        end
        if (!ok) chki("in_handshake_timeout", 0, 1);
      end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int dut);
    for (int t = 0; t < 400 && qsize(dut) > 0; t++) begin @(posedge clk); #1; end
    chki("drain_complete", qsize(dut), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, base;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; or_mode = 2'd0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 73'(rdy0), 73'(1));
    chk("rst_out_valid", 73'(ov0), 73'(0));
    chk("rst_out_last", 73'(ol0), 73'(0));
    chk("rst_busy", 73'(busy0), 73'(0));
    chk("rst_out_data", 73'(od0), 73'(0));
    chk("rst_out_valid_dut2", 73'(ov2), 73'(0));
    reset = 1'b0;

    // Identity times B gives B back.
    for (int e = 0; e < 16; e++) begin ma[e] = (e/4 == e%4) ? 1 : 0; mb[e] = e; mc[e] = e; end
    push_exp(0, 4, 4, 18, 4);
    send(0, 4, 4, 8, 0);
    chk("compute_busy", 73'(busy0), 73'(1));
    chk("compute_in_ready", 73'(rdy0), 73'(0));
    lat = 0;
    while (!ov0 && lat < 20) begin @(posedge clk); #1; lat++; end
    chki("out_valid_latency", lat, 5);
    wait_drain(0);
    chk("idle_in_ready", 73'(rdy0), 73'(1));
    chk("idle_busy", 73'(busy0), 73'(0));

    // All-ones maximum; in_valid pulses while busy must be ignored.
    for (int e = 0; e < 16; e++) begin ma[e] = 255; mb[e] = 255; mc[e] = 260100; end
    push_exp(0, 4, 4, 18, 4);
    send(0, 4, 4, 8, 0);
    in_data = 32'hDEADBEEF; in_valid = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    wait_drain(0);

    // Backpressure with out_ready toggling every cycle.
    for (int e = 0; e < 16; e++) begin ma[e] = e + 1; mb[e] = (e*3) % 7; end
    model(4);
    push_exp(0, 4, 4, 18, 4);
    or_mode = 2'd1;
    base = hs0;
    send(0, 4, 4, 8, 0);
    wait_drain(0);
    chki("bp_beat_count", hs0 - base, 4);
    or_mode = 2'd0;

    // Signed operands.
    for (int e = 0; e < 16; e++) begin ma[e] = -128; mb[e] = -128; mc[e] = 65536; end
    push_exp(1, 4, 4, 18, 4);
    send(1, 4, 4, 8, 0);
    wait_drain(1);
    for (int e = 0; e < 16; e++) begin ma[e] = -1; mb[e] = 1; mc[e] = 32'h3FFFC; end
    push_exp(1, 4, 4, 18, 4);
    send(1, 4, 4, 8, 0);
    wait_drain(1);

    // Random input gaps.
    for (int e = 0; e < 16; e++) begin ma[e] = $urandom_range(0, 255); mb[e] = $urandom_range(0, 255); end
    model(4);
    push_exp(0, 4, 4, 18, 4);
    send(0, 4, 4, 8, 1);
    wait_drain(0);

    // Reset during drain after beat 1 has been accepted.
    for (int e = 0; e < 16; e++) begin ma[e] = $urandom_range(0, 255); mb[e] = $urandom_range(0, 255); end
    model(4);
    push_exp(0, 4, 4, 18, 2);
    base = hs0;
    send(0, 4, 4, 8, 0);
    for (int t = 0; t < 100 && hs0 < base + 2; t++) begin @(posedge clk); #1; end
    chki("pre_reset_beats", hs0 - base, 2);
    or_mode = 2'd2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_out_valid", 73'(ov0), 73'(0));
    chk("midreset_in_ready", 73'(rdy0), 73'(1));
    chk("midreset_busy", 73'(busy0), 73'(0));
    chk("midreset_out_last", 73'(ol0), 73'(0));
    chk("midreset_out_data", 73'(od0), 73'(0));
    reset = 1'b0;
    or_mode = 2'd0;
    for (int e = 0; e < 16; e++) begin ma[e] = $urandom_range(0, 255); mb[e] = $urandom_range(0, 255); end
    model(4);
    push_exp(0, 4, 4, 18, 4);
    send(0, 4, 4, 8, 0);
    wait_drain(0);

    // 8x8, 4-bit operands, 2 lanes: 32 output beats, last only on beat 31.
    for (int e = 0; e < 64; e++) begin ma[e] = $urandom_range(0, 15); mb[e] = $urandom_range(0, 15); end
    model(8);
    push_exp(2, 8, 2, 11, 32);
    or_mode = 2'd1;
    send(2, 8, 2, 4, 0);
    wait_drain(2);
    or_mode = 2'd0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
